// File: rtl/nes_joypad_emulator_pkg.sv
// nes_joypad_emulator_pkg: button bit positions and width shared by the joypad emulator files
package nes_joypad_emulator_pkg;
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_W      = 8;
endpackage

// File: rtl/nes_joypad_emulator_if.sv
// nes_joypad_emulator_if: controller-port signals between the button/CPU side (master) and the emulator (slave)
interface nes_joypad_emulator_if;
  import nes_joypad_emulator_pkg::*;
  logic [BTN_W-1:0] buttons_i;
  logic             strobe_i;
  logic             read_i;
  logic             turbo_a_i;
  logic             turbo_b_i;
  logic             data_o;
  modport master (output buttons_i, strobe_i, read_i, turbo_a_i, turbo_b_i, input data_o);
  modport slave  (input buttons_i, strobe_i, read_i, turbo_a_i, turbo_b_i, output data_o);
endinterface

// File: rtl/nes_joypad_emulator_turbo_gen.sv
// nes_turbo_gen: free-running half-period counter that toggles the turbo phase, built only under NES_JOYPAD_TURBO_EN
module nes_turbo_gen #(
  parameter int unsigned HALF_PERIOD = 833333
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic phase_o
);
  localparam int unsigned W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(HALF_PERIOD - 1);
  logic [W-1:0] cnt_q, cnt_d;
  logic         phase_q, phase_d, wrap_w;
  // count 0..HALF_PERIOD-1 and flip the phase on every wrap
  always_comb begin
    wrap_w  = cnt_q == LAST;
    cnt_d   = !en_i ? cnt_q : wrap_w ? '0 : cnt_q + 1'b1;
    phase_d = phase_q ^ (en_i & wrap_w);
  end
  // counter and phase registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end
  assign phase_o = phase_q;
endmodule

// File: rtl/nes_joypad_emulator.sv
// nes_joypad_emulator: 4021-style NES controller shift register; turbo A/B enabled by NES_JOYPAD_TURBO_EN
module nes_joypad_emulator
  import nes_joypad_emulator_pkg::*;
#(
  parameter bit          MASK_OPPOSITE     = 1'b1,
  parameter int unsigned TURBO_HALF_PERIOD = 833333
) (
  input logic                  clk_i,
  input logic                  rst_i,
  nes_joypad_emulator_if.slave bus
);
  logic [BTN_W-1:0] raw_w, eff_w, shift_q, shift_d;
`ifdef NES_JOYPAD_TURBO_EN
  logic phase_w;
  nes_turbo_gen #(.HALF_PERIOD(TURBO_HALF_PERIOD)) u_turbo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (1'b1),
    .phase_o (phase_w)
  );
  // held turbo buttons read as pressed only during the active phase
  always_comb begin
    raw_w        = bus.buttons_i;
    raw_w[BTN_A] = bus.buttons_i[BTN_A] | (bus.turbo_a_i & phase_w);
    raw_w[BTN_B] = bus.buttons_i[BTN_B] | (bus.turbo_b_i & phase_w);
  end
`else
  logic unused_turbo;
  assign unused_turbo = ^{bus.turbo_a_i, bus.turbo_b_i, TURBO_HALF_PERIOD[0]};
  assign raw_w = bus.buttons_i;
`endif
  // opposing directions cancel out, then strobe reload beats read shift beats hold
  always_comb begin
    eff_w = raw_w;
    if (MASK_OPPOSITE && raw_w[BTN_UP] && raw_w[BTN_DOWN]) begin
      eff_w[BTN_UP]   = 1'b0;
      eff_w[BTN_DOWN] = 1'b0;
    end
    if (MASK_OPPOSITE && raw_w[BTN_LEFT] && raw_w[BTN_RIGHT]) begin
      eff_w[BTN_LEFT]  = 1'b0;
      eff_w[BTN_RIGHT] = 1'b0;
    end
    shift_d = bus.strobe_i ? eff_w : bus.read_i ? {1'b1, shift_q[BTN_W-1:1]} : shift_q;
  end
  // serial shift register; data_o comes straight from its LSB
  always_ff @(posedge clk_i) begin
    if (rst_i) shift_q <= '0;
    else shift_q <= shift_d;
  end
  assign bus.data_o = shift_q[0];
endmodule

// File: tb/tb_nes_joypad_emulator.sv
// tb_nes_joypad_emulator: directed bench for the joypad emulator, masked and unmasked instances side by side
module tb_nes_joypad_emulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;

  nes_joypad_emulator_if bus_m ();
  nes_joypad_emulator_if bus_r ();

  nes_joypad_emulator #(.MASK_OPPOSITE(1'b1), .TURBO_HALF_PERIOD(4)) dut_m (
    .clk_i (clk), .rst_i (rst), .bus (bus_m.slave));
  nes_joypad_emulator #(.MASK_OPPOSITE(1'b0), .TURBO_HALF_PERIOD(4)) dut_r (
    .clk_i (clk), .rst_i (rst), .bus (bus_r.slave));

  assign bus_r.buttons_i = bus_m.buttons_i;
  assign bus_r.strobe_i  = bus_m.strobe_i;
  assign bus_r.read_i    = bus_m.read_i;
  assign bus_r.turbo_a_i = bus_m.turbo_a_i;
  assign bus_r.turbo_b_i = bus_m.turbo_b_i;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic strobe_pulse();
    bus_m.strobe_i = 1'b1;
    tick();
    bus_m.strobe_i = 1'b0;
  endtask

  task automatic do_read(output logic got_m, output logic got_r);
    got_m = bus_m.data_o;
    got_r = bus_r.data_o;
    bus_m.read_i = 1'b1;
    tick();
    bus_m.read_i = 1'b0;
  endtask

  task automatic test_reset();
    logic gm, gr;
    logic [9:0] exp;
    exp = 10'b11_0000_0000;
    do_reset();
    n_checks++;
    if (bus_m.data_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %0b expected 0", bus_m.data_o);
    end
    bus_m.buttons_i = 8'h00;
    strobe_pulse();
    for (int i = 0; i < 10; i++) begin
      do_read(gm, gr);
      n_checks++;
      if (gm !== exp[i]) begin
        n_fail++;
        $display("FAIL zero_buttons_read%0d: got %0b expected %0b", i + 1, gm, exp[i]);
      end
    end
  endtask

  task automatic test_sequence();
    logic gm, gr;
    logic [7:0] exp;
    exp = 8'b1001_0101;
    bus_m.buttons_i = 8'b1001_0101;
    strobe_pulse();
    bus_m.buttons_i = 8'h00;
    for (int i = 0; i < 8; i++) begin
      do_read(gm, gr);
      n_checks++;
      if (gm !== exp[i]) begin
        n_fail++;
        $display("FAIL sequence_read%0d: got %0b expected %0b", i + 1, gm, exp[i]);
      end
    end
  endtask

  task automatic test_strobe_held();
    logic a;
    bus_m.buttons_i = 8'h02;
    bus_m.strobe_i  = 1'b1;
    for (int c = 0; c < 16; c++) begin
      a = ((c >> 2) & 1) == 1;
      bus_m.buttons_i[0] = a;
      bus_m.read_i = (c & 1) == 1;
      tick();
      n_checks++;
      if (bus_m.data_o !== a) begin
        n_fail++;
        $display("FAIL strobe_held_cycle%0d: got %0b expected %0b", c, bus_m.data_o, a);
      end
    end
    bus_m.read_i   = 1'b0;
    bus_m.strobe_i = 1'b0;
    tick();
  endtask

  task automatic test_mask();
    logic gm, gr;
    bus_m.buttons_i = 8'hF0;
    strobe_pulse();
    for (int i = 0; i < 8; i++) begin
      do_read(gm, gr);
      if (i >= 4) begin
        n_checks += 2;
        if (gm !== 1'b0) begin
          n_fail++;
          $display("FAIL mask_on_read%0d: got %0b expected 0", i + 1, gm);
        end
        if (gr !== 1'b1) begin
          n_fail++;
          $display("FAIL mask_off_read%0d: got %0b expected 1", i + 1, gr);
        end
      end
    end
  endtask

  task automatic test_strobe_read_same_cycle();
    logic gm, gr;
    bus_m.buttons_i = 8'h02;
    bus_m.strobe_i  = 1'b1;
    bus_m.read_i    = 1'b1;
    tick();
    bus_m.read_i    = 1'b0;
    n_checks++;
    if (bus_m.data_o !== 1'b0) begin
      n_fail++;
      $display("FAIL load_wins_data: got %0b expected 0", bus_m.data_o);
    end
    bus_m.strobe_i = 1'b0;
    tick();
    do_read(gm, gr);
    n_checks++;
    if (gm !== 1'b0) begin
      n_fail++;
      $display("FAIL load_wins_first_read: got %0b expected 0 (A)", gm);
    end
    do_read(gm, gr);
    n_checks++;
    if (gm !== 1'b1) begin
      n_fail++;
      $display("FAIL load_wins_second_read: got %0b expected 1 (B)", gm);
    end
  endtask

  task automatic test_reset_mid_sequence();
    logic gm, gr;
    logic [8:0] exp;
    exp = 9'b1_0000_0000;
    bus_m.buttons_i = 8'hFF;
    strobe_pulse();
    for (int i = 0; i < 3; i++) do_read(gm, gr);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      do_read(gm, gr);
      n_checks++;
      if (gm !== exp[i]) begin
        n_fail++;
        $display("FAIL reset_mid_read%0d: got %0b expected %0b", i + 1, gm, exp[i]);
      end
    end
  endtask

  task automatic test_turbo();
    logic s [24];
    int last, ntr;
    last = -1;
    ntr  = 0;
    bus_m.buttons_i = 8'h00;
    bus_m.strobe_i  = 1'b1;
    bus_m.turbo_a_i = 1'b1;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      tick();
      s[i] = bus_m.data_o;
    end
    bus_m.strobe_i  = 1'b0;
    bus_m.turbo_a_i = 1'b0;
`ifdef NES_JOYPAD_TURBO_EN
    for (int i = 1; i < 24; i++) begin
      if (s[i] !== s[i-1]) begin
        if (last >= 0) begin
          n_checks++;
          if (i - last !== 4) begin
            n_fail++;
            $display("FAIL turbo_run_length: got %0d expected 4", i - last);
          end
        end
        last = i;
        ntr++;
      end
    end
    n_checks++;
    if (ntr < 4) begin
      n_fail++;
      $display("FAIL turbo_toggles: got %0d expected at least 4", ntr);
    end
`else
    for (int i = 0; i < 24; i++) begin
      n_checks++;
      if (s[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL turbo_disabled_cycle%0d: got %0b expected 0", i, s[i]);
      end
    end
    n_checks++;
    if (ntr != 0 || last != -1) begin
      n_fail++;
      $display("FAIL turbo_disabled_state: got %0d expected 0", ntr);
    end
`endif
  endtask

  initial begin
    bus_m.buttons_i = 8'h00;
    bus_m.strobe_i  = 1'b0;
    bus_m.read_i    = 1'b0;
    bus_m.turbo_a_i = 1'b0;
    bus_m.turbo_b_i = 1'b0;
    test_reset();
    test_sequence();
    test_strobe_held();
    test_mask();
    test_strobe_read_same_cycle();
    test_reset_mid_sequence();
    test_turbo();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/nes_joypad_emulator.md
Name: nes_joypad_emulator

Overview:
- Emulates a standard NES controller (4021-style parallel-in/serial-out register) built from the board push-buttons.
- Consumes the debounced, synchronised button levels produced by the input filter stage, one filter instance per button.
- Serves the CPU-side $4016/$4017 strobe/read protocol, returning one button bit per read.
- Sits between the board button filters and the APU/IO register block.

Parameters:
- MASK_OPPOSITE, 1, 1 = report both as released when Up+Down (or Left+Right) are pressed together; 0 = pass through raw.
- TURBO_HALF_PERIOD, 833333, clock cycles per half period of the turbo toggle (used only with the optional feature).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; synchronous, active-high.
- buttons_i  input  8  filtered button levels, 1 = pressed. Bit order: 0 = A, 1 = B, 2 = Select, 3 = Start, 4 = Up, 5 = Down, 6 = Left, 7 = Right.
- strobe_i  input  1  level of controller strobe (bit 0 of the last CPU write to $4016).
- read_i  input  1  one-cycle pulse per CPU read of this controller port.
- turbo_a_i  input  1  turbo-A button level, filtered (ignored without the optional feature).
- turbo_b_i  input  1  turbo-B button level, filtered (ignored without the optional feature).
- data_o  output  1  serial button bit presented to the CPU data bus (D0), 1 = pressed.

Behaviour:
- Reset: 8-bit shift register shift_r = 8'h00; data_o = 0; turbo counter = 0; turbo phase = 0.
- data_o is always shift_r[0], driven from a register with no combinational path from the inputs.
- Effective buttons eff_w are built from buttons_i.
  - If MASK_OPPOSITE = 1 and bits 4 and 5 are both 1, both are forced to 0 in eff_w.
  - Bits 6 and 7 are treated the same way.
- Per-cycle priority:
  1. rst_i.
  2. strobe_i = 1: shift_r <= eff_w. Reloaded every cycle while strobe is high, so data_o tracks A with 1-cycle latency.
  3. read_i = 1 (strobe low): shift_r <= {1'b1, shift_r[7:1]}.
  4. Otherwise hold.
- read_i while strobe_i = 1: no shift. The read returns the current A and the register keeps reloading.
- Falling edge of strobe: the last loaded value is frozen. No extra sample is taken on the low cycle.
- Simultaneous strobe_i = 1 and read_i = 1 in the same cycle: load wins.
- Read count:
  - Reads 1..8 after the strobe drops return A, B, Select, Start, Up, Down, Left, Right.
  - Reads 9 and beyond return 1, matching official controllers, because of the 1-fill.
  - No read counter is needed and there is no wrap-around.
- Read timing: data_o updates the cycle after a read_i pulse. The IO block latches data_o during the read cycle, before the shift takes effect.
- Reset mid-sequence: shift_r goes to 0x00. Reads return 1s only after that many shifts (0 for reads 1..8, then 1).
- Button changes while strobe is low are invisible until the next strobe.

Optional Feature:
- Macro: NES_JOYPAD_TURBO_EN.
- Defined:
  - A free-running counter counts 0..TURBO_HALF_PERIOD-1. Its width is $clog2(TURBO_HALF_PERIOD).
  - On wrap, the counter returns to 0 and turbo phase toggles.
  - eff_w[0] |= turbo_a_i & phase; eff_w[1] |= turbo_b_i & phase.
  - The counter runs regardless of strobe.
- Undefined: no counter or phase logic is built; turbo_a_i and turbo_b_i are unconnected and have no effect.

Decomposition:
- Shared package holds:
  - Button bit-index constants: BTN_A = 0, BTN_B = 1, BTN_SELECT = 2, BTN_START = 3, BTN_UP = 4, BTN_DOWN = 5, BTN_LEFT = 6, BTN_RIGHT = 7.
  - Width constant BTN_W = 8.
- One natural sub-module, nes_turbo_gen: a counter plus phase toggle with enable, instantiated only under NES_JOYPAD_TURBO_EN.
- The shift register and masking stay in the top module.

Test Plan:
1. Reset, then strobe 1→0 with buttons_i = 8'h00, then 10 reads → data_o = 0 for reads 1..8; 1 for reads 9 and 10.
2. buttons_i = 8'b1001_0101 (Right, Up, Select, A); strobe pulse then 8 reads → sequence 1,0,1,0,1,0,0,1.
3. strobe held 1, toggle buttons_i[0] every 4 cycles, issue reads → data_o follows A with 1-cycle delay and never advances to B.
4. MASK_OPPOSITE = 1, buttons_i = 8'hF0 → reads 5..8 return 0,0,0,0. With MASK_OPPOSITE = 0 they return 1,1,1,1.
5. Strobe high and read_i asserted in the same cycle, then strobe low and one read → the first read after the release returns A, not B.
6. With NES_JOYPAD_TURBO_EN defined, TURBO_HALF_PERIOD = 4, turbo_a_i = 1, buttons_i = 0, strobe held high → data_o alternates 4 cycles 0 / 4 cycles 1. Without the macro, data_o stays 0.
